// File: rtl/unaligned_store_sequencer.sv
// Store sequencer in front of the data memory write port: forwards SW/SH/SB as a
// single registered write and splits SWL/SWR into per-byte writes (big-endian).
`ifndef DATA_TYPE_WORD
`define DATA_TYPE_WORD  3'd0
`endif
`ifndef DATA_TYPE_HALF
`define DATA_TYPE_HALF  3'd1
`endif
`ifndef DATA_TYPE_BYTE
`define DATA_TYPE_BYTE  3'd2
`endif
`ifndef DATA_TYPE_WORDL
`define DATA_TYPE_WORDL 3'd3
`endif
`ifndef DATA_TYPE_WORDR
`define DATA_TYPE_WORDR 3'd4
`endif

module unaligned_store_sequencer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_rt,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_type,
  output logic              stall,
  output logic              done
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e            state_q, state_d;
  logic [1:0]        beats_q, beats_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [2:0]        type_q, type_d;
  logic              seq_q, seq_d;
  logic [1:0]        a;
  logic              accept;

  assign a         = req_addr[1:0];
  assign req_ready = (state_q == IDLE) || (beats_q == 2'd0);
  assign accept    = req_valid && req_ready;

  // Sequenced beats carry their byte at the top of the shift register.
  assign mem_write = (state_q == EMIT);
  assign mem_addr  = addr_q;
  assign mem_wdata = seq_q ? {{(DATA_W-8){1'b0}}, sr_q[DATA_W-1 -: 8]} : sr_q;
  assign mem_type  = type_q;
  assign stall     = (state_q == EMIT) && (beats_q != 2'd0);
  assign done      = (state_q == EMIT) && (beats_q == 2'd0);

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    addr_d  = addr_q;
    sr_d    = sr_q;
    type_d  = type_q;
    seq_d   = seq_q;
    if (accept) begin
      state_d = EMIT;
      beats_d = 2'd0;
      addr_d  = req_addr;
      sr_d    = req_rt;
      type_d  = `DATA_TYPE_WORD;
      seq_d   = 1'b0;
      case (req_type)
        `DATA_TYPE_HALF, `DATA_TYPE_BYTE: type_d = req_type;
        `DATA_TYPE_WORDL: begin
          if (a != 2'd0) begin
            type_d  = `DATA_TYPE_BYTE;
            seq_d   = 1'b1;
            beats_d = ~a;
          end
        end
        `DATA_TYPE_WORDR: begin
          addr_d = req_addr - ADDR_W'(a);
          if (a != 2'd3) begin
            // Align byte rt[8a+7:8a] to the top so the shift emits it first.
            sr_d    = req_rt << {~a, 3'b000};
            type_d  = `DATA_TYPE_BYTE;
            seq_d   = 1'b1;
            beats_d = a;
          end
        end
        default: ;
      endcase
    end else if (state_q == EMIT) begin
      if (beats_q != 2'd0) begin
        beats_d = beats_q - 2'd1;
        addr_d  = addr_q + ADDR_W'(1);
        sr_d    = sr_q << 8;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beats_q <= 2'd0;
      addr_q  <= '0;
      sr_q    <= '0;
      type_q  <= `DATA_TYPE_WORD;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      type_q  <= type_d;
      seq_q   <= seq_d;
    end
  end

endmodule

// File: tb/tb_unaligned_store_sequencer.sv
// Directed bench for unaligned_store_sequencer with a big-endian byte memory model.
`ifndef DATA_TYPE_WORD
`define DATA_TYPE_WORD  3'd0
`endif
`ifndef DATA_TYPE_HALF
`define DATA_TYPE_HALF  3'd1
`endif
`ifndef DATA_TYPE_BYTE
`define DATA_TYPE_BYTE  3'd2
`endif
`ifndef DATA_TYPE_WORDL
`define DATA_TYPE_WORDL 3'd3
`endif
`ifndef DATA_TYPE_WORDR
`define DATA_TYPE_WORDR 3'd4
`endif

module tb_unaligned_store_sequencer;
  localparam logic [2:0] W = `DATA_TYPE_WORD, H = `DATA_TYPE_HALF, B = `DATA_TYPE_BYTE;
  localparam logic [2:0] SWL = `DATA_TYPE_WORDL, SWR = `DATA_TYPE_WORDR;

  logic clk = 1'b0;
  logic rst, req_valid, req_ready, mem_write, stall, done, clr;
  logic [2:0]  req_type, mem_type;
  logic [13:0] req_addr, mem_addr;
  logic [31:0] req_rt, mem_wdata;
  logic [7:0]  mem [0:255];
  int tests_run = 0;
  int failed = 0;

  unaligned_store_sequencer #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_rt(req_rt),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  // Big-endian memory: lowest address holds the most significant byte.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (mem_write) begin
      case (mem_type)
        `DATA_TYPE_BYTE: mem[mem_addr[7:0]] <= mem_wdata[7:0];
        `DATA_TYPE_HALF: begin
          mem[{mem_addr[7:1], 1'b0}] <= mem_wdata[15:8];
          mem[{mem_addr[7:1], 1'b1}] <= mem_wdata[7:0];
        end
        default: begin
          mem[{mem_addr[7:2], 2'd0}] <= mem_wdata[31:24];
          mem[{mem_addr[7:2], 2'd1}] <= mem_wdata[23:16];
          mem[{mem_addr[7:2], 2'd2}] <= mem_wdata[15:8];
          mem[{mem_addr[7:2], 2'd3}] <= mem_wdata[7:0];
        end
      endcase
    end
  end

  function automatic logic [52:0] snap();
    return {mem_write, mem_addr, mem_type, mem_wdata, stall, done, req_ready};
  endfunction

  function automatic logic [52:0] beat(logic w, logic [13:0] a, logic [2:0] t,
                                       logic [31:0] d, logic st, logic dn, logic rdy);
    return {w, a, t, d, st, dn, rdy};
  endfunction

  function automatic logic [31:0] word_at(logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [2:0] t, logic [13:0] a, logic [31:0] d);
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_rt    = d;
  endtask

  task automatic test_reset();
    logic [52:0] got, exp;
    rst = 1'b1; clr = 1'b1; req_valid = 1'b0;
    req_type = W; req_addr = '0; req_rt = '0;
    tick(); tick();
    got = snap(); exp = beat(1'b0, 14'h0, W, 32'h0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL reset_state: got %h exp %h", got, exp); end
    rst = 1'b0; clr = 1'b0;
    tick();
    got = snap();
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL idle_after_reset: got %h exp %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic [52:0] got, exp;
    logic [23:0] bytes;
    drive(SWL, 14'h0005, 32'hC1C2C3C4);
    tick();
    req_valid = 1'b0;
    got = snap(); exp = beat(1'b1, 14'h05, B, 32'hC1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL mid_beat1: got %h exp %h", got, exp); end
    tick();
    rst = 1'b1;
    #1;
    got = snap(); exp = beat(1'b0, 14'h0, W, 32'h0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL mid_reset_async: got %h exp %h", got, exp); end
    tick(); tick();
    rst = 1'b0;
    bytes = {mem[8'h05], mem[8'h06], mem[8'h07]};
    tests_run++;
    if (bytes !== 24'hC1A3A2) begin failed++; $display("FAIL mid_reset_mem: got %h exp %h", bytes, 24'hC1A3A2); end
    drive(W, 14'h0010, 32'h12345678);
    tick();
    req_valid = 1'b0;
    got = snap(); exp = beat(1'b1, 14'h10, W, 32'h12345678, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL post_reset_sw: got %h exp %h", got, exp); end
    tick();
    tests_run++;
    if (word_at(8'h10) !== 32'h12345678) begin
      failed++; $display("FAIL post_reset_mem: got %h exp %h", word_at(8'h10), 32'h12345678);
    end
  endtask

  task automatic test_sw();
    logic [52:0] got, exp;
    drive(W, 14'h0010, 32'hDEADBEEF);
    tick();
    req_valid = 1'b0;
    got = snap(); exp = beat(1'b1, 14'h10, W, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL sw_beat: got %h exp %h", got, exp); end
    tick();
    tests_run++;
    if (mem_write !== 1'b0) begin failed++; $display("FAIL sw_idle: got %b exp 0", mem_write); end
    drive(H, 14'h0062, 32'h0000ABCD);
    tick();
    req_valid = 1'b0;
    got = snap(); exp = beat(1'b1, 14'h62, H, 32'h0000ABCD, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL sh_beat: got %h exp %h", got, exp); end
    tick();
    drive(3'd6, 14'h0071, 32'h0BADF00D);
    tick();
    req_valid = 1'b0;
    got = snap(); exp = beat(1'b1, 14'h71, W, 32'h0BADF00D, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL unknown_type: got %h exp %h", got, exp); end
    tick();
  endtask

  task automatic test_swl();
    logic [52:0] got, exp;
    logic [13:0] ea [3] = '{14'h21, 14'h22, 14'h23};
    logic [7:0]  ed [3] = '{8'h11, 8'h22, 8'h33};
    logic        es [3] = '{1'b1, 1'b1, 1'b0};
    logic        en [3] = '{1'b0, 1'b0, 1'b1};
    drive(SWL, 14'h0021, 32'h11223344);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = snap(); exp = beat(1'b1, ea[i], B, {24'h0, ed[i]}, es[i], en[i], en[i]);
      tests_run++;
      if (got !== exp) begin failed++; $display("FAIL swl_beat%0d: got %h exp %h", i, got, exp); end
      tick();
    end
    tests_run++;
    if (word_at(8'h20) !== 32'h85112233) begin
      failed++; $display("FAIL swl_mem: got %h exp %h", word_at(8'h20), 32'h85112233);
    end
  endtask

  task automatic test_swr();
    logic [52:0] got, exp;
    logic [13:0] ea [3] = '{14'h30, 14'h31, 14'h32};
    logic [7:0]  ed [3] = '{8'hBB, 8'hCC, 8'hDD};
    logic        es [3] = '{1'b1, 1'b1, 1'b0};
    logic        en [3] = '{1'b0, 1'b0, 1'b1};
    drive(SWR, 14'h0032, 32'hAABBCCDD);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = snap(); exp = beat(1'b1, ea[i], B, {24'h0, ed[i]}, es[i], en[i], en[i]);
      tests_run++;
      if (got !== exp) begin failed++; $display("FAIL swr_beat%0d: got %h exp %h", i, got, exp); end
      tick();
    end
    tests_run++;
    if (word_at(8'h30) !== 32'hBBCCDD96) begin
      failed++; $display("FAIL swr_mem: got %h exp %h", word_at(8'h30), 32'hBBCCDD96);
    end
  endtask

  task automatic test_aligned();
    logic [52:0] got, exp;
    drive(SWL, 14'h0040, 32'h01020304);
    tick();
    req_valid = 1'b0;
    got = snap(); exp = beat(1'b1, 14'h40, W, 32'h01020304, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL swl_aligned: got %h exp %h", got, exp); end
    tick();
    drive(SWR, 14'h0047, 32'h05060708);
    tick();
    req_valid = 1'b0;
    got = snap(); exp = beat(1'b1, 14'h44, W, 32'h05060708, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL swr_aligned: got %h exp %h", got, exp); end
    tick();
    tests_run++;
    if ({word_at(8'h40), word_at(8'h44)} !== 64'h01020304_05060708) begin
      failed++; $display("FAIL aligned_mem: got %h exp %h", {word_at(8'h40), word_at(8'h44)}, 64'h01020304_05060708);
    end
  endtask

  task automatic test_back_to_back();
    logic [52:0] got, exp;
    logic [13:0] ea [3] = '{14'h51, 14'h52, 14'h53};
    logic [7:0]  ed [3] = '{8'h99, 8'h88, 8'h77};
    logic        es [3] = '{1'b1, 1'b1, 1'b0};
    logic        en [3] = '{1'b0, 1'b0, 1'b1};
    drive(SWL, 14'h0051, 32'h99887766);
    tick();
    drive(B, 14'h0060, 32'h0000007F);
    for (int i = 0; i < 3; i++) begin
      got = snap(); exp = beat(1'b1, ea[i], B, {24'h0, ed[i]}, es[i], en[i], en[i]);
      tests_run++;
      if (got !== exp) begin failed++; $display("FAIL b2b_swl_beat%0d: got %h exp %h", i, got, exp); end
      tick();
    end
    req_valid = 1'b0;
    got = snap(); exp = beat(1'b1, 14'h60, B, 32'h0000007F, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (got !== exp) begin failed++; $display("FAIL b2b_sb_beat: got %h exp %h", got, exp); end
    tick();
    tests_run++;
    if ({mem_write, done} !== 2'b00) begin failed++; $display("FAIL b2b_no_double: got %b exp 00", {mem_write, done}); end
    tests_run++;
    if ({word_at(8'h50), mem[8'h60]} !== 40'hF5998877_7F) begin
      failed++; $display("FAIL b2b_mem: got %h exp %h", {word_at(8'h50), mem[8'h60]}, 40'hF5998877_7F);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_sw();
    test_swl();
    test_swr();
    test_aligned();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
